dmem_bhw: RTL and testbench

Parametrised byte-addressable data memory for the mini-MIPS load/store path, successor to the word-only data memory. Supports byte/halfword/word accesses with sign or zero extension, a valid/ready request port, a configurable read latency and a sequenced clear after reset. It sits between the MEM pipeline stage and the backing array, and stalls the pipeline through `req_ready`.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_lane_fmt.sv | 49 ++++
 rtl/dmem_bhw.sv | 128 ++++++++++++
 tb/tb_dmem_bhw.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes and controller states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Lane formatter: byte-enable and store replication for writes, lane select and extension for loads.
// Low address bits are always masked to the access alignment; misalign_o reports what was masked.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o       = '0;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    byte_sel   = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_sel   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      default: begin
        // Word and reserved size share the full-word path; reserved always counts as misaligned.
        misalign_o = (addr_lo_i != 2'b00) || (size_i != SZ_WORD);
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bhw.sv
// Byte/half/word data memory with valid/ready request port, READ_LAT response latency and post-reset clear.
// Optional DMEM_MISALIGN_TRAP_EN rejects misaligned or reserved-size accesses with rsp_err.
module dmem_bhw
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [31:0]      mem_q [DEPTH_WORDS];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_q, clr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;
  logic             misalign;
  logic             reject;
  logic             accept;
  logic             unused_addr;

  assign idx         = req_addr[IDX_W+1:2];
  assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];
  assign rword       = mem_q[idx];
  assign accept      = (state_q == IDLE) && req_valid;
  assign reject      = TRAP_EN && misalign;

  dmem_lane_fmt u_fmt (
    .size_i     (req_size),
    .signed_i   (req_signed),
    .addr_lo_i  (req_addr[1:0]),
    .wdata_i    (req_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (st_wdata),
    .rdata_o    (ld_data),
    .misalign_o (misalign)
  );

  // Array has no reset of its own; INIT sweeps it to zero one word per cycle.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[clr_q] <= '0;
    end else if (accept && req_we && !reject) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be[k]) mem_q[idx][8*k +: 8] <= st_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == IDX_W'(DEPTH_WORDS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (req_valid) begin
          rdata_d = (req_we || reject) ? '0 : ld_data;
          err_d   = reject;
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = (READ_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Leave on the cycle the count would hit zero so RESP lands exactly READ_LAT after accept.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      clr_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_bhw.sv
// Self-checking bench for dmem_bhw (DEPTH_WORDS=16, READ_LAT=3) against a byte-level reference model.
module tb_dmem_bhw;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  dmem_bhw #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as bytes in little-endian words; access width in bytes, aligned down unless trapping.
  task automatic model_op(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] exp_rd, output logic exp_err);
    int unsigned nb, off, w;
    longint unsigned mask, v;
    bit bad;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off  = addr % 4;
    bad  = ((addr % nb) != 0) || (size == 2'd3);
    w    = (addr / 4) % DEPTH;
    mask = (64'd1 << (8 * nb)) - 1;
    exp_rd  = '0;
    exp_err = 1'b0;
    if (TRAP && bad) begin
      exp_err = 1'b1;
      return;
    end
    off = off - (off % nb);
    if (we) begin
      for (int unsigned b = 0; b < nb; b++) begin
        v = (wdata >> (8 * b)) & 32'hFF;
        mdl[w] = (mdl[w] & ~(32'hFF << (8 * (off + b)))) | 32'(v << (8 * (off + b)));
      end
    end else begin
      v = (longint'(mdl[w]) >> (8 * off)) & mask;
      if (sgn && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v | (64'hFFFF_FFFF & ~mask);
      exp_rd = 32'(v);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int unsigned n = 0;
    got = '0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    model_op(we, size, sgn, addr, wdata, exp_rd, exp_err);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      chk("busy_ready", {31'd0, req_ready}, 32'd0);
      chk("rsp_valid_t", {31'd0, rsp_valid}, (k == int'(LAT)) ? 32'd1 : 32'd0);
      if (k == int'(LAT)) begin
        got = rsp_rdata;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      end
    end
    @(negedge clk);
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);

    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("init_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("init_ready_rise", {31'd0, req_ready}, 32'd1);

    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, got);
    chk("lw8_cleared", got, 32'h0000_0000);
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, got);
    do_req(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, got);
    chk("lb8_s", got, 32'hFFFF_FFEF);
    do_req(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, got);
    chk("lbu9", got, 32'h0000_00BE);
    do_req(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, got);
    chk("lhA_s", got, 32'hFFFF_DEAD);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, got);
    chk("lhuA", got, 32'h0000_DEAD);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, got);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
    chk("lw10_sb", got, 32'h1122_AA44);
    do_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, got);
    chk("lw50_wrap", got, 32'h1122_AA44);

    do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'h0000_0055, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, got);
    chk("misalign_sw_effect", got, TRAP ? 32'h0 : 32'h0000_0055);
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, got);
    chk("misalign_lw", got, TRAP ? 32'h0 : 32'h0000_0055);

    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), $urandom, got);
    end

    // Reset while a store sits in WAIT: it was already committed, but INIT must wipe everything.
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_valid_rst", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ready_rst", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("reinit_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reinit_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("reinit_rise", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_req(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0, got);
      chk("post_reset_zero", got, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
